// File: rtl/maze_store_if.sv
// Load and solver ports of the maze map store. The store is the slave side;
// the loader/solver (or a bench driving both) is the master side.
interface maze_store_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CNT_W  = 13
);
    localparam int unsigned SIDE = 1 << ADDR_W;

    logic              load_valid;
    logic              load_ready;
    logic [SIDE-1:0]   load_data;
    logic              load_start;
    logic              map_ready;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic              maze_oe;
    logic              maze_we;
    logic              maze_in;
    logic              solver_done;
    logic              exit_valid;
    logic [ADDR_W-1:0] exit_row;
    logic [ADDR_W-1:0] exit_col;
    logic [CNT_W-1:0]  visited_count;
    logic              wr_wall_err;

    modport slave (
        input  load_valid, load_data, load_start, row, col, maze_oe, maze_we, solver_done,
        output load_ready, map_ready, maze_in, exit_valid, exit_row, exit_col,
               visited_count, wr_wall_err
    );

    modport master (
        output load_valid, load_data, load_start, row, col, maze_oe, maze_we, solver_done,
        input  load_ready, map_ready, maze_in, exit_valid, exit_row, exit_col,
               visited_count, wr_wall_err
    );
endinterface

// File: rtl/maze_store.sv
// Maze map store: row-per-beat wall map load, 1-cycle solver reads, visited
// marking with a distinct-cell counter, and exit-cell capture on solver done.
module maze_store #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CNT_W  = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    maze_store_if.slave   bus
);
    localparam int unsigned SIDE = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, LOAD, READY, DONE} state_t;

    state_t state, next_state;

    logic [SIDE-1:0]   wall_mem    [SIDE];
    logic [SIDE-1:0]   visited_mem [SIDE];

    logic [ADDR_W-1:0] ctr;
    logic              done_q;
    logic              load_ready_q, map_ready_q, maze_in_q;
    logic              exit_valid_q, wr_wall_err_q;
    logic [ADDR_W-1:0] exit_row_q, exit_col_q;
    logic [CNT_W-1:0]  count_q;

    logic              load_ready_d, map_ready_d;
    logic              accept, last_row, done_rise, we_ok, enter_load, map_live;
    logic              cell_wall, cell_visited;

    assign map_live     = (state == READY) || (state == DONE);
    assign accept       = (state == LOAD) && load_ready_q && bus.load_valid && !bus.load_start;
    assign last_row     = (ctr == ADDR_W'(SIDE - 1));
    assign done_rise    = (state == READY) && bus.solver_done && !done_q;
    assign we_ok        = (state == READY) && bus.maze_we;
    assign enter_load   = (next_state == LOAD) && ((state != LOAD) || bus.load_start);
    assign cell_wall    = wall_mem[bus.row][bus.col];
    assign cell_visited = visited_mem[bus.row][bus.col];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; load_start overrides every other transition
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = LOAD;
            LOAD:  if (!bus.load_start && accept && last_row) next_state = READY;
            READY: if (bus.load_start)  next_state = LOAD;
                   else if (done_rise)  next_state = DONE;
            DONE:  if (bus.load_start)  next_state = LOAD;
        endcase
    end

    // Port-status outputs, registered from the upcoming state
    always_comb begin
        load_ready_d = 1'b0;
        map_ready_d  = 1'b0;
        if (next_state == LOAD)                          load_ready_d = 1'b1;
        if ((next_state == READY) || (next_state == DONE)) map_ready_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_ready_q  <= 1'b0;
            map_ready_q   <= 1'b0;
            maze_in_q     <= 1'b1;
            done_q        <= 1'b0;
            ctr           <= '0;
            count_q       <= '0;
            exit_valid_q  <= 1'b0;
            exit_row_q    <= '0;
            exit_col_q    <= '0;
            wr_wall_err_q <= 1'b0;
        end else begin
            load_ready_q <= load_ready_d;
            map_ready_q  <= map_ready_d;
            done_q       <= bus.solver_done;

            // Until the map is live the solver sees only walls
            if (!map_live)        maze_in_q <= 1'b1;
            else if (bus.maze_oe) maze_in_q <= cell_wall;

            if (enter_load) begin
                ctr           <= '0;
                count_q       <= '0;
                exit_valid_q  <= 1'b0;
                wr_wall_err_q <= 1'b0;
            end else begin
                if (accept) ctr <= ctr + 1'b1;
                if (we_ok) begin
                    if (!cell_visited && (count_q != CNT_MAX)) count_q <= count_q + 1'b1;
                    if (cell_wall) wr_wall_err_q <= 1'b1;
                end
                if (done_rise) begin
                    exit_valid_q <= 1'b1;
                    exit_row_q   <= bus.row;
                    exit_col_q   <= bus.col;
                end
            end
        end
    end

    // Map arrays are not reset; a load beat rewrites the wall row and clears its visited row
    always_ff @(posedge clk) begin
        if (accept) begin
            wall_mem[ctr]    <= bus.load_data;
            visited_mem[ctr] <= '0;
        end else if (we_ok) begin
            visited_mem[bus.row][bus.col] <= 1'b1;
        end
    end

    assign bus.load_ready    = load_ready_q;
    assign bus.map_ready     = map_ready_q;
    assign bus.maze_in       = maze_in_q;
    assign bus.exit_valid    = exit_valid_q;
    assign bus.exit_row      = exit_row_q;
    assign bus.exit_col      = exit_col_q;
    assign bus.visited_count = count_q;
    assign bus.wr_wall_err   = wr_wall_err_q;
endmodule

// File: tb/tb_maze_store.sv
// Directed bench for maze_store: load, reads, visited marking, exit capture,
// reload and reset recovery, each compared against hand-derived values.
module tb_maze_store;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [63:0] map [64];

    maze_store_if #(.ADDR_W(6), .CNT_W(13)) bus ();

    maze_store #(.ADDR_W(6), .CNT_W(13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed rows [first, first+n) while load_valid is held; inv selects the inverted map
    task automatic load_beats(input int first, input int n, input bit inv);
        int k;
        int guard;
        bit acc;
        k = first;
        guard = 0;
        while (k < first + n && guard < 500) begin
            bus.load_valid = 1'b1;
            bus.load_data  = inv ? ~map[k] : map[k];
            acc = bus.load_ready;
            step();
            guard++;
            if (acc) k++;
        end
        bus.load_valid = 1'b0;
        chk("load_beats_taken", 64'(k), 64'(first + n));
    endtask

    task automatic rd(input string tag, input int r, input int c, input logic expv);
        bus.row     = 6'(r);
        bus.col     = 6'(c);
        bus.maze_oe = 1'b1;
        step();
        bus.maze_oe = 1'b0;
        chk(tag, 64'(bus.maze_in), 64'(expv));
    endtask

    task automatic wr(input int r, input int c);
        bus.row     = 6'(r);
        bus.col     = 6'(c);
        bus.maze_we = 1'b1;
        step();
        bus.maze_we = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int r = 0; r < 64; r++) begin
            if (r == 5)       map[r] = 64'h8;
            else if (r == 20) map[r] = 64'hF0;
            else if (r == 63) map[r] = '1;
            else              map[r] = 64'(r);
        end

        rst_n = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_data   = '0;
        bus.load_start  = 1'b0;
        bus.row         = '0;
        bus.col         = '0;
        bus.maze_oe     = 1'b0;
        bus.maze_we     = 1'b0;
        bus.solver_done = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_load_ready", 64'(bus.load_ready), 64'(0));
        chk("rst_map_ready", 64'(bus.map_ready), 64'(0));
        chk("rst_maze_in", 64'(bus.maze_in), 64'(1));
        chk("rst_exit_valid", 64'(bus.exit_valid), 64'(0));
        chk("rst_exit_col", 64'(bus.exit_col), 64'(0));
        chk("rst_count", 64'(bus.visited_count), 64'(0));
        chk("rst_wall_err", 64'(bus.wr_wall_err), 64'(0));

        // 1: full load with load_valid held from reset release
        rst_n = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = map[0];
        chk("idle_load_ready", 64'(bus.load_ready), 64'(0));
        step();
        chk("load_ready_clk2", 64'(bus.load_ready), 64'(1));
        load_beats(0, 63, 1'b0);
        chk("map_ready_before_last", 64'(bus.map_ready), 64'(0));
        chk("maze_in_during_load", 64'(bus.maze_in), 64'(1));
        load_beats(63, 1, 1'b0);
        chk("map_ready_after_last", 64'(bus.map_ready), 64'(1));
        chk("load_ready_after_last", 64'(bus.load_ready), 64'(0));
        chk("count_after_load", 64'(bus.visited_count), 64'(0));

        // 2: back-to-back reads (5,3) wall then (5,4) open, then hold
        bus.row = 6'd5; bus.col = 6'd3; bus.maze_oe = 1'b1;
        step();
        chk("rd_5_3", 64'(bus.maze_in), 64'(1));
        bus.col = 6'd4;
        step();
        chk("rd_5_4", 64'(bus.maze_in), 64'(0));
        bus.maze_oe = 1'b0;
        bus.col = 6'd3;
        step();
        chk("rd_hold", 64'(bus.maze_in), 64'(0));
        rd("rd_10_1", 10, 1, 1'b1);
        rd("rd_20_4", 20, 4, 1'b1);
        rd("rd_20_3", 20, 3, 1'b0);
        rd("rd_63_40", 63, 40, 1'b1);
        rd("rd_0_0", 0, 0, 1'b0);

        // 3: repeated marks count once
        wr(10, 10);
        chk("cnt_first_mark", 64'(bus.visited_count), 64'(1));
        wr(10, 10);
        wr(10, 10);
        wr(10, 11);
        chk("cnt_distinct", 64'(bus.visited_count), 64'(2));
        chk("no_wall_err", 64'(bus.wr_wall_err), 64'(0));

        // 4: mark a wall cell, then a read+mark on one cell, then an open cell
        wr(5, 3);
        chk("wall_err_set", 64'(bus.wr_wall_err), 64'(1));
        chk("cnt_wall_mark", 64'(bus.visited_count), 64'(3));
        bus.maze_we = 1'b1;
        rd("rd_with_we_10_12", 10, 12, 1'b0);
        bus.maze_we = 1'b0;
        chk("cnt_rd_we", 64'(bus.visited_count), 64'(4));
        wr(12, 0);
        chk("cnt_open_mark", 64'(bus.visited_count), 64'(5));
        chk("wall_err_sticky", 64'(bus.wr_wall_err), 64'(1));

        // 5: exit capture on done rise, writes ignored afterwards
        bus.row = 6'd0; bus.col = 6'd17; bus.solver_done = 1'b1;
        step();
        chk("exit_valid", 64'(bus.exit_valid), 64'(1));
        chk("exit_row", 64'(bus.exit_row), 64'(0));
        chk("exit_col", 64'(bus.exit_col), 64'(17));
        bus.row = 6'd9; bus.col = 6'd9;
        step();
        chk("exit_col_held", 64'(bus.exit_col), 64'(17));
        wr(30, 30);
        chk("cnt_after_done", 64'(bus.visited_count), 64'(5));
        rd("rd_in_done", 5, 3, 1'b1);
        bus.solver_done = 1'b0;

        // 6a: load_start from DONE clears status
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        chk("restart_map_ready", 64'(bus.map_ready), 64'(0));
        chk("restart_load_ready", 64'(bus.load_ready), 64'(1));
        chk("restart_exit_valid", 64'(bus.exit_valid), 64'(0));
        chk("restart_count", 64'(bus.visited_count), 64'(0));
        chk("restart_wall_err", 64'(bus.wr_wall_err), 64'(0));
        rd("rd_in_load", 0, 0, 1'b1);

        // 6b: 30 beats of inverted map, restart with a colliding beat, full reload
        load_beats(0, 30, 1'b1);
        bus.load_start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = '0;
        step();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        load_beats(0, 64, 1'b1);
        chk("reload_map_ready", 64'(bus.map_ready), 64'(1));
        rd("rl_0_0", 0, 0, 1'b1);
        rd("rl_1_0", 1, 0, 1'b0);
        rd("rl_5_3", 5, 3, 1'b0);
        rd("rl_5_4", 5, 4, 1'b1);
        wr(10, 10);
        chk("rl_cnt", 64'(bus.visited_count), 64'(1));
        chk("rl_wall_err", 64'(bus.wr_wall_err), 64'(1));

        // 6c: async reset mid-READY, reload with solver_done already high
        #2 rst_n = 1'b0;
        #1;
        chk("arst_map_ready", 64'(bus.map_ready), 64'(0));
        chk("arst_maze_in", 64'(bus.maze_in), 64'(1));
        chk("arst_count", 64'(bus.visited_count), 64'(0));
        chk("arst_load_ready", 64'(bus.load_ready), 64'(0));
        step();
        rst_n = 1'b1;
        bus.solver_done = 1'b1;
        step();
        chk("arst_load_ready_back", 64'(bus.load_ready), 64'(1));
        rd("rd_after_arst", 0, 0, 1'b1);
        load_beats(0, 64, 1'b0);
        chk("arst_reload_ready", 64'(bus.map_ready), 64'(1));
        step();
        chk("done_high_on_entry", 64'(bus.exit_valid), 64'(0));
        wr(10, 10);
        chk("arst_cnt_cleared", 64'(bus.visited_count), 64'(1));
        chk("arst_no_wall_err", 64'(bus.wr_wall_err), 64'(0));
        rd("arst_rd_10_10", 10, 10, 1'b0);
        rd("arst_rd_5_3", 5, 3, 1'b1);
        bus.solver_done = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
